pulse_delay_timer: RTL and testbench
====================================

Name: pulse_delay_timer

Overview:
Multi-channel, parametrised pulse delay timer and successor to the single fixed-delay pulse delayer. Each channel watches its trigger for a rising edge, counts a per-channel programmable number of cycles, then emits a one-cycle output pulse. The block adds a runtime delay value, a selectable retrigger mode, a per-channel cancel input, and sticky overrun reporting. It sits between the control/sequencing logic and the FP adder datapath, where it generates delayed start and done strobes.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CNT_W, 6, width of each channel's delay value and counter
DEF_DELAY, 32, delay used when a channel's delay_in slice is 0

Ports:
clk_in  input  1  system clock; all state changes on the rising edge
rst_n_in  input  1  asynchronous, active-low reset
trig_in  input  NUM_CH  per-channel trigger; a rising edge starts or retriggers the channel
cancel_in  input  NUM_CH  per-channel synchronous abort, level-sampled
delay_in  input  NUM_CH*CNT_W  per-channel delay D; slice [i*CNT_W +: CNT_W] belongs to channel i
retrig_mode_in  input  1  0 = ignore triggers while busy, 1 = restart the count on a trigger while busy
ovr_clr_in  input  1  synchronous clear of all ovr_out bits
out  output  NUM_CH  one-cycle delayed pulse per channel, registered
busy_out  output  NUM_CH  channel is counting, registered
ovr_out  output  NUM_CH  sticky flag: a trigger arrived while busy, registered

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - out, busy_out and ovr_out go to 0.
  - All counters go to 0.
  - All trigger-history registers go to 0.
  - A trig_in held high through reset is therefore seen as a rising edge on the first clock edge after reset is released.
  - Reset asserted mid-count aborts the count with no pulse.
- Trigger event for channel i at edge k: trig_in[i]=1 at edge k and trig_in[i]=0 at edge k-1. A held-high level produces exactly one event.
- Effective delay: Deff = delay_in slice sampled at the event edge. If that slice is 0, Deff = DEF_DELAY (truncated to CNT_W bits; if the truncated value is 0, Deff = 1). delay_in changes during a count have no effect.
- Per-channel FSM, IDLE/COUNT:
  - IDLE, event at edge k: go to COUNT, busy_out=1 after edge k, load the counter.
  - COUNT: out[i]=1 for exactly the cycle following edge k+Deff, and busy_out[i] drops to 0 at that same edge. Trigger-to-pulse latency is Deff cycles.
  - COUNT, event before expiry, retrig_mode_in=0: the event is ignored, the count continues, and ovr_out[i] is set.
  - COUNT, event before expiry, retrig_mode_in=1: the counter reloads with the new Deff, the pulse moves to new event edge + Deff, and ovr_out[i] is set.
  - Event on the same edge as expiry (edge k+Deff): out pulses, the channel stays in COUNT with the new load, busy_out stays 1, and ovr_out is not set. This gives back-to-back pulses every Deff cycles.
- Cancel: cancel_in[i]=1 at an edge forces IDLE and clears the counter. There is no out pulse, even on the expiry edge. Cancel has priority over the event and expiry on that edge, and it still updates the trigger history.
- ovr_clr_in=1 clears all ovr_out bits. If a set and a clear hit the same bit on the same edge, the set wins.
- Channels are fully independent. There is no shared arbitration.
- out is a pure register output: no combinational path from inputs to outputs.
- retrig_mode_in is global and sampled every edge. It affects only events that occur while a channel is busy.

Test Plan:
1. Reset release, CNT_W=6, ch0 delay=5, trig_in[0] rises at edge 10 and stays high -> busy_out[0]=1 after edge 10, out[0]=1 only after edge 15, a single pulse, ovr_out=0.
2. delay_in slice = 0 with DEF_DELAY=32 -> out pulses 32 cycles after the event. A 6-bit delay of 63 -> 63 cycles.
3. retrig_mode_in=0, D=8, second rising edge 3 cycles after the first -> pulse still at event1+8, ovr_out=1. ovr_clr_in pulse -> ovr_out=0.
4. retrig_mode_in=1, D=8, retrigger at event1+3 -> no pulse at event1+8, pulse at event1+11, ovr_out=1.
5. D=4, trig_in toggling every 4 cycles -> out pulses every 4 cycles, busy_out continuously 1, ovr_out stays 0. Also drive cancel_in on an expiry edge -> no pulse, busy_out=0.
6. All 4 channels with D=1,2,3,4 triggered on the same edge -> out bits 0..3 fire on successive cycles. Drop rst_n_in mid-count -> all outputs 0 immediately, no pulses after release.

Source files
------------

// File: rtl/pulse_delay_timer.sv
// Multi-channel pulse delay timer: a rising trigger edge starts a per-channel
// programmable count that ends in a one-cycle registered output pulse.
module pulse_delay_timer #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 6,
  parameter int DEF_DELAY = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_CH-1:0]       trig_in,
  input  logic [NUM_CH-1:0]       cancel_in,
  input  logic [NUM_CH*CNT_W-1:0] delay_in,
  input  logic                    retrig_mode_in,
  input  logic                    ovr_clr_in,
  output logic [NUM_CH-1:0]       out,
  output logic [NUM_CH-1:0]       busy_out,
  output logic [NUM_CH-1:0]       ovr_out
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } ch_state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] DEF_TRUNC = CNT_W'(DEF_DELAY);
  localparam logic [CNT_W-1:0] DEF_EFF   = (DEF_TRUNC == CNT_ZERO) ? CNT_ONE : DEF_TRUNC;

  function automatic logic [CNT_W-1:0] eff_delay(input logic [CNT_W-1:0] d);
    if (d == CNT_ZERO) begin
      eff_delay = DEF_EFF;
    end else begin
      eff_delay = d;
    end
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_deff;
    logic             r_trig_d;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_busy;
    logic             r_ovr;
    logic             w_ovr_set;
    logic             w_ovr_nxt;
    logic             w_evt;
    logic             w_expire;

    assign w_evt    = trig_in[g] & ~r_trig_d;
    assign w_deff   = eff_delay(delay_in[g*CNT_W +: CNT_W]);
    assign w_expire = (r_state == ST_COUNT) && (r_cnt == CNT_ONE);

    // Channel state, counter, trigger history and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        r_state  <= ST_IDLE;
        r_cnt    <= CNT_ZERO;
        r_trig_d <= 1'b0;
        r_out    <= 1'b0;
        r_busy   <= 1'b0;
        r_ovr    <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_trig_d <= trig_in[g];
        r_out    <= w_out_nxt;
        r_busy   <= (w_state_nxt == ST_COUNT);
        r_ovr    <= w_ovr_nxt;
      end
    end

    // Next state: cancel beats expiry and events; an event landing on the
    // expiry edge chains a new count without flagging an overrun.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = 1'b0;
      w_ovr_set   = 1'b0;
      if (cancel_in[g]) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_evt) begin
              w_state_nxt = ST_COUNT;
              w_cnt_nxt   = w_deff;
            end else begin
              w_cnt_nxt   = CNT_ZERO;
            end
          end
          ST_COUNT: begin
            if (w_expire) begin
              w_out_nxt = 1'b1;
              if (w_evt) begin
                w_cnt_nxt = w_deff;
              end else begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
              end
            end else if (w_evt) begin
              w_ovr_set = 1'b1;
              if (retrig_mode_in) begin
                w_cnt_nxt = w_deff;
              end else begin
                w_cnt_nxt = r_cnt - CNT_ONE;
              end
            end else begin
              w_cnt_nxt = r_cnt - CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end
        endcase
      end
      if (w_ovr_set) begin
        w_ovr_nxt = 1'b1;
      end else if (ovr_clr_in) begin
        w_ovr_nxt = 1'b0;
      end else begin
        w_ovr_nxt = r_ovr;
      end
    end

    assign out[g]      = r_out;
    assign busy_out[g] = r_busy;
    assign ovr_out[g]  = r_ovr;
  end

endmodule

// File: tb/tb_pulse_delay_timer.sv
// Directed bench for pulse_delay_timer; expected pulses are queued when
// triggers are driven and retired on the cycle they are due.
module tb_pulse_delay_timer;
  localparam int NCH = 4;
  localparam int CW  = 6;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic [NCH-1:0]    trig_in;
  logic [NCH-1:0]    cancel_in;
  logic [NCH*CW-1:0] delay_in;
  logic              retrig_mode_in;
  logic              ovr_clr_in;
  logic [NCH-1:0]    out;
  logic [NCH-1:0]    busy_out;
  logic [NCH-1:0]    ovr_out;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  pulse_delay_timer #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DELAY(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .trig_in(trig_in), .cancel_in(cancel_in),
    .delay_in(delay_in), .retrig_mode_in(retrig_mode_in), .ovr_clr_in(ovr_clr_in),
    .out(out), .busy_out(busy_out), .ovr_out(ovr_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_out();
    logic [NCH-1:0] e;
    e = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        e[sb[i].ch] = 1'b1;
        sb.delete(i);
      end
    end
    chk("out", {28'd0, out}, {28'd0, e});
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expect a pulse on ch d cycles after the next edge (d=0 means default 32).
  task automatic expect_pulse(input int ch, input int d);
    exp_t e;
    e.ch  = ch;
    e.cyc = cyc + 1 + ((d == 0) ? 32 : d);
    sb.push_back(e);
  endtask

  task automatic set_delay(input int ch, input int d);
    delay_in[ch*CW +: CW] = CW'(d);
  endtask

  initial begin
    int e1;
    checks = 0; errors = 0; cyc = 0;
    rst_n_in = 1'b0; trig_in = '0; cancel_in = '0; delay_in = '0;
    retrig_mode_in = 1'b0; ovr_clr_in = 1'b0;

    // Reset state
    tick_n(3);
    chk("rst_busy", {28'd0, busy_out}, 32'd0);
    chk("rst_ovr", {28'd0, ovr_out}, 32'd0);
    rst_n_in = 1'b1;
    cyc = 0;

    // 1: D=5, trigger rises at edge 10 and stays high
    set_delay(0, 5);
    tick_n(9);
    trig_in[0] = 1'b1;
    expect_pulse(0, 5);
    tick();
    chk("t1_busy_start", {31'd0, busy_out[0]}, 32'd1);
    tick_n(4);
    chk("t1_busy_mid", {31'd0, busy_out[0]}, 32'd1);
    tick();
    chk("t1_busy_end", {31'd0, busy_out[0]}, 32'd0);
    tick_n(6);
    chk("t1_ovr", {28'd0, ovr_out}, 32'd0);
    trig_in[0] = 1'b0;
    tick();

    // 2: default delay, then maximum delay
    set_delay(0, 0);
    trig_in[0] = 1'b1; expect_pulse(0, 0); tick(); trig_in[0] = 1'b0;
    tick_n(36);
    set_delay(0, 63);
    trig_in[0] = 1'b1; expect_pulse(0, 63); tick(); trig_in[0] = 1'b0;
    chk("t2_busy", {31'd0, busy_out[0]}, 32'd1);
    tick_n(66);
    chk("t2_idle", {31'd0, busy_out[0]}, 32'd0);

    // 3: ignore-mode retrigger sets ovr, pulse unchanged
    set_delay(0, 8);
    retrig_mode_in = 1'b0;
    e1 = cyc + 1;
    trig_in[0] = 1'b1; expect_pulse(0, 8); tick(); trig_in[0] = 1'b0;
    tick_n(2);
    trig_in[0] = 1'b1; tick(); trig_in[0] = 1'b0;
    chk("t3_retrig_edge", cyc, e1 + 3);
    chk("t3_ovr_set", {31'd0, ovr_out[0]}, 32'd1);
    tick_n(8);
    chk("t3_ovr_hold", {31'd0, ovr_out[0]}, 32'd1);
    ovr_clr_in = 1'b1; tick(); ovr_clr_in = 1'b0;
    chk("t3_ovr_clr", {28'd0, ovr_out}, 32'd0);

    // 4: restart-mode retrigger moves the pulse; set beats clear
    retrig_mode_in = 1'b1;
    trig_in[0] = 1'b1; tick(); trig_in[0] = 1'b0;
    tick_n(2);
    trig_in[0] = 1'b1; ovr_clr_in = 1'b1; expect_pulse(0, 8); tick();
    trig_in[0] = 1'b0; ovr_clr_in = 1'b0;
    chk("t4_ovr_set_wins", {31'd0, ovr_out[0]}, 32'd1);
    tick_n(10);
    chk("t4_ovr_hold", {31'd0, ovr_out[0]}, 32'd1);
    ovr_clr_in = 1'b1; tick(); ovr_clr_in = 1'b0;
    retrig_mode_in = 1'b0;

    // 5: back-to-back pulses every 4 cycles, then cancel on expiry edge
    set_delay(0, 4);
    for (int j = 0; j < 4; j++) begin
      trig_in[0] = 1'b1;
      if (j < 3) expect_pulse(0, 4);
      tick(); chk("t5_busy", {31'd0, busy_out[0]}, 32'd1);
      tick(); trig_in[0] = 1'b0; chk("t5_busy", {31'd0, busy_out[0]}, 32'd1);
      tick(); chk("t5_busy", {31'd0, busy_out[0]}, 32'd1);
      tick(); chk("t5_busy", {31'd0, busy_out[0]}, 32'd1);
    end
    chk("t5_ovr", {28'd0, ovr_out}, 32'd0);
    cancel_in[0] = 1'b1; tick(); cancel_in[0] = 1'b0;
    chk("t5_cancel_busy", {31'd0, busy_out[0]}, 32'd0);
    tick_n(3);

    // 6: four channels, staggered delays, same trigger edge
    for (int i = 0; i < NCH; i++) begin
      set_delay(i, i + 1);
      expect_pulse(i, i + 1);
    end
    trig_in = 4'hF; tick(); trig_in = 4'h0;
    chk("t6_busy_all", {28'd0, busy_out}, 32'hF);
    tick_n(5);
    chk("t6_idle_all", {28'd0, busy_out}, 32'h0);

    // 6b: reset mid-count aborts everything
    for (int i = 0; i < NCH; i++) set_delay(i, 10);
    trig_in = 4'hF; tick(); trig_in = 4'h0;
    tick_n(2);
    chk("t6_busy_pre_rst", {28'd0, busy_out}, 32'hF);
    rst_n_in = 1'b0;
    #1;
    chk("t6_rst_busy", {28'd0, busy_out}, 32'h0);
    chk("t6_rst_out", {28'd0, out}, 32'h0);
    tick_n(2);
    rst_n_in = 1'b1;
    tick_n(15);
    chk("t6_post_busy", {28'd0, busy_out}, 32'h0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
